// File: rtl/wand_spi_tx.sv
// wand_spi_tx: captures one 32-bit APA102 frame (start, LED colour or end)
// on a rising edge of tx_start. It then shifts the frame out MSB-first in
// SPI mode 0. Each sck phase lasts CLK_DIV clocks. tx_busy covers the whole
// frame plus one closing cycle.
module wand_spi_tx #(
  parameter int unsigned CLK_DIV           = 4,
  parameter logic [4:0]  GLOBAL_BRIGHTNESS = 5'h1f
) (
  input  logic       wand_spi_tx_clk,
  input  logic       wand_spi_tx_reset,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
  input  logic [1:0] type_input,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       mosi,
  output logic       sck
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        start_q;
  logic        start_edge;
  logic [31:0] frame;

  // Resetting start_q to 1 means a tx_start already high at reset release
  // does not count as an edge.
  assign start_edge = tx_start & ~start_q;

  // Frame word selected by the frame type; types 2 and 3 both give the end frame
  always_comb begin
    frame = 32'hFFFF_FFFF;
    case (type_input)
      2'd0:    frame = 32'h0000_0000;
      2'd1:    frame = {3'b111, GLOBAL_BRIGHTNESS, blue_input, green_input, red_input};
      default: frame = 32'hFFFF_FFFF;
    endcase
  end

  // Next-state and output logic for the serializer FSM
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start_edge) begin
          shift_d   = frame;
          mosi_d    = frame[31];
          busy_d    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (div_cnt_q == DIV_LAST) begin
          sck_d     = 1'b1;
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_HIGH: begin
        if (div_cnt_q == DIV_LAST) begin
          sck_d     = 1'b0;
          div_cnt_d = '0;
          if (bit_cnt_q == 5'd31) begin
            state_d = S_DONE;
          end else begin
            // mosi changes together with the sck falling edge
            shift_d   = {shift_q[30:0], 1'b0};
            mosi_d    = shift_q[30];
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything immediately, mid-frame included
  always_ff @(posedge wand_spi_tx_clk or posedge wand_spi_tx_reset) begin
    if (wand_spi_tx_reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      start_q   <= tx_start;
    end
  end

  assign tx_busy = busy_q;
  assign mosi    = mosi_q;
  assign sck     = sck_q;

endmodule

// File: tb/tb_wand_spi_tx.sv
// Bench for wand_spi_tx. Instance A uses CLK_DIV=2 and instance B uses
// CLK_DIV=1. The bench decodes the serial stream on sck rising edges and
// measures the phase widths and the busy length. Results are compared with
// frame words computed from the frame-format rules.
module tb_wand_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] blue, green, red;
  logic [1:0] ftype;
  logic       tx_start_a, tx_start_b;
  logic       busy_a, mosi_a, sck_a;
  logic       busy_b, mosi_b, sck_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wand_spi_tx #(.CLK_DIV(2), .GLOBAL_BRIGHTNESS(5'h1f)) u_dut_a (
    .wand_spi_tx_clk  (clk),
    .wand_spi_tx_reset(rst),
    .blue_input       (blue),
    .green_input      (green),
    .red_input        (red),
    .type_input       (ftype),
    .tx_start         (tx_start_a),
    .tx_busy          (busy_a),
    .mosi             (mosi_a),
    .sck              (sck_a)
  );

  wand_spi_tx #(.CLK_DIV(1), .GLOBAL_BRIGHTNESS(5'h1f)) u_dut_b (
    .wand_spi_tx_clk  (clk),
    .wand_spi_tx_reset(rst),
    .blue_input       (blue),
    .green_input      (green),
    .red_input        (red),
    .type_input       (ftype),
    .tx_start         (tx_start_b),
    .tx_busy          (busy_b),
    .mosi             (mosi_b),
    .sck              (sck_b)
  );

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  b;
    logic [7:0]  g;
    logic [7:0]  r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Reference frame word built arithmetically from the frame-format rules
  function automatic logic [31:0] ref_word(input logic [1:0] t, input logic [7:0] b,
                                           input logic [7:0] g, input logic [7:0] r);
    logic [31:0] w;
    if (t == 2'd0)      w = 32'd0;
    else if (t == 2'd1) w = ((32'hE0 | 32'h1f) << 24) + (32'(b) << 16) + (32'(g) << 8) + 32'(r);
    else                w = 32'hFFFF_FFFF;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) tx_start_b = v;
    else          tx_start_a = v;
  endtask

  // Counts negedges with any sck or busy activity on the selected instance
  task automatic idle_watch(input int sel, input int n, output int act);
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel == 1) begin
        if (sck_b || busy_b) act++;
      end else begin
        if (sck_a || busy_a) act++;
      end
    end
  endtask

  // Follows one frame from the cycle after tx_start rises until busy falls.
  // mode 0: 2-cycle start pulse; 1: start held high; 2: toggle start and
  // scramble inputs from bit 10; 3: reset at bit 10; 4: start edge in DONE.
  task automatic watch(input int sel, input int div, input int mode,
                       output logic [31:0] word, output int nbits, output int blen,
                       output int bad, output logic to, output logic rst_bad);
    logic s, m, b, sp, seen, fell;
    int   hi, lo;
    word = '0; nbits = 0; blen = 0; bad = 0; hi = 0; lo = 0;
    sp = 1'b0; seen = 1'b0; fell = 1'b0; rst_bad = 1'b0;
    for (int k = 0; k < 64 * div + 40; k++) begin
      @(negedge clk);
      s = (sel == 1) ? sck_b  : sck_a;
      m = (sel == 1) ? mosi_b : mosi_a;
      b = (sel == 1) ? busy_b : busy_a;
      if (b) begin
        blen++;
        seen = 1'b1;
      end else if (seen) begin
        fell = 1'b1;
        break;
      end
      if (s && !sp) begin
        word = {word[30:0], m};
        nbits++;
        if (lo != div) bad++;
        lo = 0;
      end
      if (s) begin
        hi++;
      end else begin
        if (sp) begin
          if (hi != div) bad++;
          hi = 0;
        end
        if (b) lo++;
      end
      sp = s;
      if (k == 1 && mode != 1) set_start(sel, 1'b0);
      if (mode == 2 && nbits >= 10 && nbits < 14) begin
        set_start(sel, (sel == 1) ? ~tx_start_b : ~tx_start_a);
        blue  = 8'($urandom);
        green = 8'($urandom);
        red   = 8'($urandom);
        ftype = 2'($urandom);
      end
      if (mode == 3 && nbits == 10) begin
        rst = 1'b1;
        #1;
        if (sck_a || mosi_a || busy_a) rst_bad = 1'b1;
        fell = 1'b1;
        break;
      end
      if (mode == 4 && nbits == 32 && !s && b) set_start(sel, 1'b1);
    end
    to = ~fell;
  endtask

  logic [31:0] w, exp;
  int          nb, bl, bd, act, total, badsum;
  logic        to, rb;

  // Runs one mode-0 frame on instance A and checks word, bit count, busy length and phase widths
  task automatic frame_a(input string name, input logic [31:0] e);
    tx_start_a = 1'b1;
    watch(0, 2, 0, w, nb, bl, bd, to, rb);
    $display("frame %s type=%0d b=%02h g=%02h r=%02h word=%08h busy=%0d", name, ftype, blue, green, red, w, bl);
    chk({name, "_word"},  w, e);
    chk({name, "_bits"},  32'(nb), 32'd32);
    chk({name, "_busy"},  32'(bl), 32'd129);
    chk({name, "_phase"}, 32'(bd), 32'd0);
    chk({name, "_timeout"}, 32'(to), 32'd0);
  endtask

  initial begin
    vecs[0] = '{t: 2'd1, b: 8'h80, g: 8'h02, r: 8'hF0, exp: 32'hFF80_02F0};
    vecs[1] = '{t: 2'd0, b: 8'hAA, g: 8'hBB, r: 8'hCC, exp: 32'h0000_0000};
    vecs[2] = '{t: 2'd2, b: 8'h12, g: 8'h34, r: 8'h56, exp: 32'hFFFF_FFFF};
    vecs[3] = '{t: 2'd3, b: 8'h00, g: 8'h00, r: 8'h00, exp: 32'hFFFF_FFFF};
    vecs[4] = '{t: 2'd1, b: 8'h00, g: 8'h00, r: 8'h00, exp: 32'hFF00_0000};
    vecs[5] = '{t: 2'd1, b: 8'h01, g: 8'hA5, r: 8'h3C, exp: 32'hFF01_A53C};

    rst = 1'b1; tx_start_a = 1'b1; tx_start_b = 1'b0;
    blue = '0; green = '0; red = '0; ftype = '0;
    repeat (3) @(negedge clk);
    chk("reset_sck",  32'(sck_a),  32'd0);
    chk("reset_mosi", 32'(mosi_a), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    idle_watch(0, 200, act);
    $display("reset release with start held: activity=%0d", act);
    chk("start_held_through_reset", 32'(act), 32'd0);
    tx_start_a = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      ftype = vecs[i].t; blue = vecs[i].b; green = vecs[i].g; red = vecs[i].r;
      frame_a($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      ftype = 2'($urandom_range(0, 3));
      blue  = 8'($urandom); green = 8'($urandom); red = 8'($urandom);
      frame_a($sformatf("rnd%0d", i), ref_word(ftype, blue, green, red));
    end

    // Toggling start and scrambling inputs mid-frame must not disturb it
    ftype = 2'd1; blue = 8'h5A; green = 8'hC3; red = 8'h0F;
    exp = ref_word(ftype, blue, green, red);
    tx_start_a = 1'b1;
    watch(0, 2, 2, w, nb, bl, bd, to, rb);
    $display("frame interfere word=%08h busy=%0d", w, bl);
    chk("interfere_word", w, exp);
    chk("interfere_busy", 32'(bl), 32'd129);
    idle_watch(0, 150, act);
    chk("interfere_no_extra", 32'(act), 32'd0);
    tx_start_a = 1'b0;
    @(negedge clk);

    // Start held high past completion must not retrigger
    ftype = 2'd2;
    tx_start_a = 1'b1;
    watch(0, 2, 1, w, nb, bl, bd, to, rb);
    $display("frame hold word=%08h busy=%0d", w, bl);
    chk("hold_word", w, 32'hFFFF_FFFF);
    idle_watch(0, 200, act);
    chk("hold_no_retrigger", 32'(act), 32'd0);
    tx_start_a = 1'b0;
    @(negedge clk);

    // A start edge landing in the closing cycle is dropped
    ftype = 2'd0;
    tx_start_a = 1'b1;
    watch(0, 2, 4, w, nb, bl, bd, to, rb);
    $display("frame done-edge word=%08h busy=%0d", w, bl);
    chk("done_edge_word", w, 32'h0000_0000);
    idle_watch(0, 150, act);
    chk("done_edge_ignored", 32'(act), 32'd0);
    tx_start_a = 1'b0;
    @(negedge clk);

    // Reset at bit 10, then a fresh frame must be complete and correct
    ftype = 2'd1; blue = 8'h11; green = 8'h22; red = 8'h33;
    tx_start_a = 1'b1;
    watch(0, 2, 3, w, nb, bl, bd, to, rb);
    $display("frame reset-mid bits=%0d", nb);
    chk("midreset_clear", 32'(rb), 32'd0);
    chk("midreset_bits",  32'(nb), 32'd10);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    blue = 8'h44; green = 8'h55; red = 8'h66;
    frame_a("post_reset", ref_word(ftype, blue, green, red));

    // Upstream sequence on the CLK_DIV=1 instance, frames back to back
    total = 0; badsum = 0;
    for (int f = 0; f < 48; f++) begin
      if (f == 0)       ftype = 2'd0;
      else if (f == 47) ftype = 2'd2;
      else              ftype = 2'd1;
      blue = 8'(f); green = 8'(f + 1); red = 8'(3 * f);
      exp = ref_word(ftype, blue, green, red);
      tx_start_b = 1'b1;
      watch(1, 1, 0, w, nb, bl, bd, to, rb);
      $display("stream frame %0d type=%0d word=%08h busy=%0d", f, ftype, w, bl);
      chk($sformatf("stream%0d_word", f), w, exp);
      chk($sformatf("stream%0d_busy", f), 32'(bl), 32'd65);
      total += nb;
      badsum += bd;
      if (to) chk($sformatf("stream%0d_timeout", f), 32'(to), 32'd0);
    end
    chk("stream_pulses", 32'(total), 32'd1536);
    chk("stream_gaps",   32'(badsum), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wand_spi_tx.md
Name: wand_spi_tx

Overview:
SPI serializer for the wand's APA102-style LED string. It sits directly downstream of the string/colour generator. On each start request it captures one 32-bit frame: a string start frame, one LED colour frame, or a string end frame. It then shifts that frame out MSB-first on mosi/sck and holds busy high until the last bit has completed.

Parameters:
CLK_DIV, 4, sck half-period in clock cycles; legal range 1..65535
GLOBAL_BRIGHTNESS, 5'h1f, 5-bit global brightness field inserted into every LED frame

Ports:
wand_spi_tx_clk  input  1  system clock (100 MHz)
wand_spi_tx_reset  input  1  asynchronous, active-high reset
blue_input  input  8  blue value, sampled only at start edge
green_input  input  8  green value, sampled only at start edge
red_input  input  8  red value, sampled only at start edge
type_input  input  2  0 = start frame, 1 = LED frame, 2 = end frame, 3 = end frame
tx_start  input  1  request; a rising edge starts one frame
tx_busy  output  1  high while a frame is in flight
mosi  output  1  serial data to the LED string
sck  output  1  serial clock to the LED string; idles low

Behaviour:
- Clocking and reset: one clock, wand_spi_tx_clk. Reset wand_spi_tx_reset is asynchronous and active-high.
- Reset values: tx_busy=0, sck=0, mosi=0, state=IDLE, shift register=0, bit_cnt=0, div_cnt=0, start_d=1.
  - start_d=1 means a tx_start held high through reset release does not trigger; a fresh low-to-high edge is required.
- Edge detect: start_d <= tx_start every cycle. Start edge = tx_start & ~start_d.
- Frame formats (32 bits, MSB first):
  - Type 0: 32'h00000000.
  - Type 1: {3'b111, GLOBAL_BRIGHTNESS, blue, green, red}.
  - Type 2 or 3: 32'hFFFFFFFF.
- State machine:
  - IDLE: outputs low, tx_busy=0. On start edge: load frame into shift register, mosi<=frame[31], tx_busy<=1, div_cnt<=0, bit_cnt<=0, go LOW.
  - LOW: sck=0, mosi stable. When div_cnt==CLK_DIV-1: sck<=1, div_cnt<=0, go HIGH. Otherwise div_cnt++.
  - HIGH: sck=1. When div_cnt==CLK_DIV-1:
    - sck<=0, div_cnt<=0.
    - If bit_cnt==31: go DONE.
    - Otherwise shift left 1, mosi<=next bit, bit_cnt++, go LOW.
    - Otherwise (div_cnt<CLK_DIV-1): div_cnt++.
  - DONE: mosi<=0, tx_busy<=0, go IDLE (one cycle).
- Timing and latency:
  - tx_busy rises the cycle after the start edge is sampled.
  - tx_busy stays high for exactly 64*CLK_DIV+1 cycles.
  - A new frame can start on the first IDLE cycle after tx_busy falls.
- Data changes on sck falling edges; the string samples on sck rising edges (SPI mode 0). Each sck high and low phase lasts CLK_DIV cycles.
- Inputs are sampled only in the start-edge cycle. Changes to colour or type inputs during busy have no effect on the frame in flight.
- Start edges arriving while not in IDLE are ignored, not queued.
- tx_start held high across frame completion does not retrigger. The upstream two-cycle start pulse yields exactly one frame.
- A start edge in the same cycle as DONE is ignored. Upstream must wait for tx_busy=0 before re-requesting.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is abandoned; no resumption.
- CLK_DIV=1 must work: sck period = 2 clocks.

Test Plan:
- Reset: assert reset mid-operation -> sck=0, mosi=0, tx_busy=0 within the same cycle. After release, with tx_start held high, no sck activity for 200 cycles.
- LED frame, CLK_DIV=2, BRIGHTNESS=5'h1f, type=1, b=0x80, g=0x02, r=0xF0, 2-cycle start pulse:
  - Bits captured on 32 sck rising edges = 0xFF8002F0.
  - tx_busy high for 129 cycles.
  - Exactly 32 sck pulses, each high for 2 cycles.
- Start frame (type 0) -> 32 zeros. End frame (type 2) -> 32 ones. Type 3 -> 32 ones. Colour inputs are ignored for all three.
- Interference:
  - Toggle tx_start and randomize colour inputs at bit 10 -> frame unchanged, no extra frame.
  - Hold tx_start high past completion -> tx_busy stays low afterwards.
- Reset asserted at bit 10 of a type 1 frame -> outputs clear immediately. A new start edge after release -> complete, correct frame.
- Upstream-model sequence (start, 46 LED frames with incrementing colours, end), CLK_DIV=1:
  - Decoded stream matches expected words.
  - Exactly 48*32 sck pulses.
  - No gap violations.
